kiwi_npu_seq: RTL and testbench

Time-multiplexed, parametrised successor of the fully-unrolled MLP inference engine. It evaluates a whole multi-layer perceptron on a small pool of `NUM_LANES` shared MAC lanes, one layer at a time, using ping-pong activation buffers. It has valid/ready handshakes on input and output, per-layer ReLU options, fixed-point rescaling and a sticky saturation flag. It sits between the host-side operand loader and the result collector, replacing the unrolled engine where area matters more than latency.

---
 rtl/kiwi_npu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_kiwi_npu_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kiwi_npu_seq.sv
// kiwi_npu_seq: time-multiplexed MLP inference engine.
// A shared pool of MAC lanes evaluates one layer at a time over ping-pong buffers.
package kiwi_npu_pkg;
  function automatic int lsize(input logic [2047:0] s, input int n, input int j);
    return int'(s[(n-1-j)*8 +: 8]);
  endfunction

  function automatic int max_size(input logic [2047:0] s, input int n);
    int m;
    m = 0;
    for (int k = 0; k < n; k++)
      if (lsize(s, n, k) > m) m = lsize(s, n, k);
    return m;
  endfunction

  function automatic int w_base(input logic [2047:0] s, input int n, input int j);
    int t;
    t = 0;
    for (int k = 1; k < n; k++)
      if (k < j) t += lsize(s, n, k) * lsize(s, n, k-1);
    return t;
  endfunction

  function automatic int b_base(input logic [2047:0] s, input int n, input int j);
    int t;
    t = 0;
    for (int k = 1; k < n; k++)
      if (k < j) t += lsize(s, n, k);
    return t;
  endfunction
endpackage

module kiwi_npu_seq
  import kiwi_npu_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter logic [NUM_LAYERS*8-1:0] LAYER_SIZES = {8'd4, 8'd8, 8'd4},
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES = 4,
  parameter int FRAC_BITS = 0,
  parameter bit RELU_HIDDEN = 1'b1,
  parameter bit RELU_OUT = 1'b0,
  localparam logic [2047:0] SZ = 2048'(LAYER_SIZES),
  localparam int S0 = lsize(SZ, NUM_LAYERS, 0),
  localparam int SL = lsize(SZ, NUM_LAYERS, NUM_LAYERS-1),
  localparam int W_BITS = w_base(SZ, NUM_LAYERS, NUM_LAYERS) * DATA_WIDTH,
  localparam int B_BITS = b_base(SZ, NUM_LAYERS, NUM_LAYERS) * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [S0*DATA_WIDTH-1:0] in_vec,
  input  logic [W_BITS-1:0] weights_flat,
  input  logic [B_BITS-1:0] biases_flat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SL*DATA_WIDTH-1:0] out_vec,
  output logic              busy,
  output logic              sat_flag
);
  localparam int DW = DATA_WIDTH;
  localparam int L = NUM_LANES;
  localparam int MAX_S = max_size(SZ, NUM_LAYERS);
  localparam int AW = 2*DW + $clog2(MAX_S) + 1;
  localparam int BW = MAX_S * DW;
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = ~MAXV;

  typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;
  state_t state, state_nxt;

  logic [7:0] layer, grp, idx;
  logic sel;
  logic [BW-1:0] buf_a, buf_b, dst;
  logic signed [AW-1:0] acc [L];
  logic signed [AW-1:0] acc_nxt [L];
  logic signed [AW-1:0] v_l [L];
  logic signed [DW-1:0] w_l [L];
  logic signed [DW-1:0] b_l [L];
  logic signed [DW-1:0] wb_val [L];
  logic signed [DW-1:0] act_i;
  int lane_o [L];
  int s_cur, s_prev, w_off, b_off;
  logic [L-1:0] lane_act, lane_sat, clip;
  logic [SL*DW-1:0] fin_vec;
  logic relu_en, last_i, more_grp, more_lyr;

  always_comb begin
    s_cur = lsize(SZ, NUM_LAYERS, int'(layer));
    s_prev = lsize(SZ, NUM_LAYERS, int'(layer) - 1);
    w_off = w_base(SZ, NUM_LAYERS, int'(layer)) * DW;
    b_off = b_base(SZ, NUM_LAYERS, int'(layer)) * DW;
    relu_en = (int'(layer) == NUM_LAYERS-1) ? RELU_OUT : RELU_HIDDEN;
    last_i = int'(idx) == s_prev - 1;
    more_grp = (int'(grp) + 1) * L < s_cur;
    more_lyr = int'(layer) < NUM_LAYERS - 1;
    act_i = sel ? buf_b[int'(idx)*DW +: DW] : buf_a[int'(idx)*DW +: DW];
    dst = sel ? buf_a : buf_b;
  end

  // Final results: earlier groups already sit in dst, the current group is overlaid.
  always_comb begin
    fin_vec = dst[SL*DW-1:0];
    lane_act = '0;
    lane_sat = '0;
    clip = '0;
    for (int l = 0; l < L; l++) begin
      lane_o[l] = int'(grp) * L + l;
      lane_act[l] = lane_o[l] < s_cur;
      w_l[l] = weights_flat[w_off + (lane_o[l]*s_prev + int'(idx))*DW +: DW];
      b_l[l] = biases_flat[b_off + lane_o[l]*DW +: DW];
      acc_nxt[l] = lane_act[l] ? acc[l] + AW'(w_l[l]) * AW'(act_i) : acc[l];
      v_l[l] = (acc[l] >>> FRAC_BITS) + AW'(b_l[l]);
      if (v_l[l] > MAXV) begin
        wb_val[l] = MAXV[DW-1:0];
        clip[l] = 1'b1;
      end else if (v_l[l] < MINV) begin
        wb_val[l] = MINV[DW-1:0];
        clip[l] = 1'b1;
      end else begin
        wb_val[l] = v_l[l][DW-1:0];
      end
      if (relu_en && wb_val[l][DW-1]) wb_val[l] = '0;
      lane_sat[l] = lane_act[l] & clip[l];
      if (lane_act[l] && lane_o[l] < SL)
        fin_vec[lane_o[l]*DW +: DW] = wb_val[l];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (in_valid) state_nxt = MAC;
      MAC:  if (last_i) state_nxt = WB;
      WB:   state_nxt = (more_grp || more_lyr) ? MAC : DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = state == IDLE;
    busy = state != IDLE;
    out_valid = state == DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      layer <= 8'd1;
      grp <= '0;
      idx <= '0;
      sel <= 1'b0;
      buf_a <= '0;
      buf_b <= '0;
      sat_flag <= 1'b0;
      out_vec <= '0;
      for (int l = 0; l < L; l++) acc[l] <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          buf_a <= BW'(in_vec);
          sat_flag <= 1'b0;
          layer <= 8'd1;
          grp <= '0;
          idx <= '0;
          sel <= 1'b0;
          for (int l = 0; l < L; l++) acc[l] <= '0;
        end
        MAC: begin
          for (int l = 0; l < L; l++) acc[l] <= acc_nxt[l];
          idx <= idx + 8'd1;
        end
        WB: begin
          for (int l = 0; l < L; l++) begin
            acc[l] <= '0;
            if (lane_act[l]) begin
              if (sel) buf_a[lane_o[l]*DW +: DW] <= wb_val[l];
              else buf_b[lane_o[l]*DW +: DW] <= wb_val[l];
            end
          end
          sat_flag <= sat_flag | (|lane_sat);
          idx <= '0;
          if (more_grp) begin
            grp <= grp + 8'd1;
          end else if (more_lyr) begin
            sel <= ~sel;
            layer <= layer + 8'd1;
            grp <= '0;
          end else begin
            out_vec <= fin_vec;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_kiwi_npu_seq.sv
// tb_kiwi_npu_seq: table vectors, handshake/reset sequences and a
// random sweep against a plain-arithmetic MLP model.
module tb_kiwi_npu_seq;
  localparam int DW = 8;
  localparam int S [3] = '{4, 8, 4};

  typedef struct packed {
    logic [31:0] in_p;
    logic [7:0]  wv;
    logic [31:0] b2;
    logic [31:0] ex;
    logic        es;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] in_vec = '0;
  logic [511:0] weights_flat;
  logic [95:0] biases_flat;
  logic in_ready, out_valid, busy, sat_flag;
  logic [31:0] out_vec;

  logic sw_valid = 1'b0;
  logic sw_ready = 1'b1;
  logic [2:0] sw_in_ready, sw_out_valid, sw_busy, sw_sat;
  logic [31:0] sw_out [3];

  int n_vec = 0;
  int n_fail = 0;
  int wt [3][8][8];
  int bs [3][8];
  logic [31:0] m_out;
  bit m_sat;

  always #5 clk = ~clk;

  kiwi_npu_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .weights_flat(weights_flat), .biases_flat(biases_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy), .sat_flag(sat_flag)
  );

  kiwi_npu_seq #(.NUM_LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[0]),
    .in_vec(in_vec), .weights_flat(weights_flat), .biases_flat(biases_flat),
    .out_valid(sw_out_valid[0]), .out_ready(sw_ready), .out_vec(sw_out[0]),
    .busy(sw_busy[0]), .sat_flag(sw_sat[0])
  );

  kiwi_npu_seq #(.NUM_LANES(3)) u_l3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[1]),
    .in_vec(in_vec), .weights_flat(weights_flat), .biases_flat(biases_flat),
    .out_valid(sw_out_valid[1]), .out_ready(sw_ready), .out_vec(sw_out[1]),
    .busy(sw_busy[1]), .sat_flag(sw_sat[1])
  );

  kiwi_npu_seq #(.NUM_LANES(8)) u_l8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[2]),
    .in_vec(in_vec), .weights_flat(weights_flat), .biases_flat(biases_flat),
    .out_valid(sw_out_valid[2]), .out_ready(sw_ready), .out_vec(sw_out[2]),
    .busy(sw_busy[2]), .sat_flag(sw_sat[2])
  );

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  task automatic pack_cfg();
    int wo, bo;
    wo = 0;
    bo = 0;
    weights_flat = '0;
    biases_flat = '0;
    for (int j = 1; j < 3; j++) begin
      for (int o = 0; o < S[j]; o++) begin
        biases_flat[(bo+o)*DW +: DW] = bs[j][o][7:0];
        for (int i = 0; i < S[j-1]; i++)
          weights_flat[(wo + o*S[j-1] + i)*DW +: DW] = wt[j][o][i][7:0];
      end
      wo += S[j] * S[j-1];
      bo += S[j];
    end
  endtask

  task automatic set_uniform(input int wv, input logic [31:0] b2);
    for (int j = 0; j < 3; j++)
      for (int o = 0; o < 8; o++) begin
        bs[j][o] = 0;
        for (int i = 0; i < 8; i++) wt[j][o][i] = wv;
      end
    for (int o = 0; o < 4; o++) bs[2][o] = int'($signed(b2[o*8 +: 8]));
    pack_cfg();
  endtask

  // Reference: layer by layer dot products, clamp to int8, ReLU on the hidden layer.
  task automatic model(input logic [31:0] inp);
    int a [8];
    int nx [8];
    int s, v;
    m_sat = 1'b0;
    for (int i = 0; i < 8; i++) a[i] = 0;
    for (int i = 0; i < 4; i++) a[i] = int'($signed(inp[i*8 +: 8]));
    for (int j = 1; j < 3; j++) begin
      for (int o = 0; o < 8; o++) nx[o] = 0;
      for (int o = 0; o < S[j]; o++) begin
        s = 0;
        for (int i = 0; i < S[j-1]; i++) s += wt[j][o][i] * a[i];
        v = s + bs[j][o];
        if (v > 127) begin v = 127; m_sat = 1'b1; end
        else if (v < -128) begin v = -128; m_sat = 1'b1; end
        if (j < 2 && v < 0) v = 0;
        nx[o] = v;
      end
      for (int o = 0; o < 8; o++) a[o] = nx[o];
    end
    for (int o = 0; o < 4; o++) m_out[o*8 +: 8] = a[o][7:0];
  endtask

  function automatic int exp_lat(input int l);
    int t;
    t = 0;
    for (int j = 1; j < 3; j++) t += ((S[j] + l - 1) / l) * (S[j-1] + 1);
    return t;
  endfunction

  task automatic accept(input logic [31:0] v);
    @(negedge clk);
    in_vec = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit busy_ok);
    busy_ok = busy;
    lat = -1;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run(input logic [31:0] v, output logic [31:0] o, output int lat,
                     output bit s, output bit bok);
    accept(v);
    wait_out(lat, bok);
    o = out_vec;
    s = sat_flag;
    release_out();
  endtask

  vec_t tbl [5];
  logic [31:0] got, inp;
  int lat, wr;
  bit s, bok, ok_v, ok_o, ok_r;
  int sw_lat [3];
  int lanes [3] = '{1, 3, 8};

  initial begin
    tbl[0] = '{in_p:32'h04030201, wv:8'd0,   b2:32'hF807FA05, ex:32'hF807FA05, es:1'b0};
    tbl[1] = '{in_p:32'h01010101, wv:8'd1,   b2:32'h0,        ex:32'h20202020, es:1'b0};
    tbl[2] = '{in_p:32'hFFFFFFFF, wv:8'd1,   b2:32'h0,        ex:32'h00000000, es:1'b0};
    tbl[3] = '{in_p:32'h7F7F7F7F, wv:8'd127, b2:32'h0,        ex:32'h7F7F7F7F, es:1'b1};
    tbl[4] = '{in_p:32'h04030201, wv:8'd0,   b2:32'h0,        ex:32'h00000000, es:1'b0};
    set_uniform(0, 32'h0);
    #1 rst_n = 1'b0;
    #11;
    chk("reset_state", {in_ready, out_valid, busy, sat_flag, out_vec},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      set_uniform(int'(tbl[t].wv), tbl[t].b2);
      run(tbl[t].in_p, got, lat, s, bok);
      chk($sformatf("tbl%0d_out", t), got, tbl[t].ex);
      chk($sformatf("tbl%0d_lat", t), lat, 19);
      chk($sformatf("tbl%0d_sat", t), s, tbl[t].es);
      chk($sformatf("tbl%0d_busy", t), bok, 1);
    end

    // Backpressure: result must hold and new requests must be ignored.
    set_uniform(1, 32'h0);
    accept(32'h01010101);
    wait_out(lat, bok);
    ok_v = 1'b1;
    ok_o = 1'b1;
    ok_r = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(0, 1));
      in_vec = $urandom;
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1) ok_v = 1'b0;
      if (out_vec !== 32'h20202020) ok_o = 1'b0;
      if (in_ready !== 1'b0 || busy !== 1'b1) ok_r = 1'b0;
    end
    chk("bp_valid_held", ok_v, 1);
    chk("bp_vec_held", ok_o, 1);
    chk("bp_no_accept", ok_r, 1);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hs_idle", {in_ready, out_valid, busy}, 3'b100);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hs_reaccept", {busy, in_ready}, 2'b10);
    wait_out(lat, bok);
    release_out();

    // Reset in the middle of an inference.
    set_uniform(0, 32'hF807FA05);
    accept(32'h04030201);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_state", {in_ready, out_valid, busy, sat_flag, out_vec},
        {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    run(32'h04030201, got, lat, s, bok);
    chk("postrst_out", got, 32'hF807FA05);
    chk("postrst_lat", lat, 19);

    for (int it = 0; it < 12; it++) begin
      wr = (it % 2 == 1) ? 128 : 4;
      for (int j = 1; j < 3; j++)
        for (int o = 0; o < 8; o++) begin
          bs[j][o] = int'($urandom_range(0, 2*wr-1)) - wr;
          for (int i = 0; i < 8; i++)
            wt[j][o][i] = int'($urandom_range(0, 2*wr-1)) - wr;
        end
      pack_cfg();
      inp = $urandom;
      model(inp);
      run(inp, got, lat, s, bok);
      chk($sformatf("rnd%0d_out", it), got, m_out);
      chk($sformatf("rnd%0d_sat", it), s, m_sat);
      chk($sformatf("rnd%0d_lat", it), lat, exp_lat(4));
    end

    // Lane-count sweep on identical operands.
    set_uniform(1, 32'h0);
    in_vec = 32'h01010101;
    for (int d = 0; d < 3; d++) sw_lat[d] = -1;
    @(negedge clk);
    sw_valid = 1'b1;
    @(posedge clk);
    #1;
    sw_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
        if (sw_out_valid[d] && sw_lat[d] < 0) sw_lat[d] = k;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("lanes%0d_lat", lanes[d]), sw_lat[d], exp_lat(lanes[d]));
      chk($sformatf("lanes%0d_out", lanes[d]), sw_out[d], 32'h20202020);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
